decode_ctrl_stage: RTL and testbench

Registered decode/control stage for the RV64I pipeline. It sits between the IF/ID and ID/EX boundaries. It decodes full opcode/funct3/funct7 fields, including parametrised Zba and M-extension support and illegal-instruction detection, and captures the control bundle into an ID/EX register with stall and flush handling. It also owns a latency counter that holds multi-cycle MUL/DIV operations in EX and requests an upstream freeze.

---
 rtl/decode_ctrl_stage.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_decode_ctrl_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: RV64I decode with optional Zba and M, illegal-instruction
// detection, an ID/EX control register with stall/flush, and a down-counter
// that keeps multi-cycle MUL/DIV ops in EX while freezing the front end.
module decode_ctrl_stage #(
    parameter bit          EN_ZBA  = 1'b1,
    parameter bit          EN_M    = 1'b1,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned DIV_LAT = 33,
    parameter int unsigned CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_i,
    input  logic        valid_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        e_valid,
    output logic [1:0]  e_ResultSrc,
    output logic        e_MemWrite,
    output logic        e_ALUSrc,
    output logic        e_RegWrite,
    output logic        e_Branch,
    output logic        e_Jump,
    output logic        e_is_jalr,
    output logic [2:0]  e_ImmSrc,
    output logic [4:0]  e_ALUControl,
    output logic        e_illegal,
    output logic        md_busy,
    output logic        stall_o
);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_SUB    = 5'b00001;
    localparam logic [4:0] ALU_AND    = 5'b00010;
    localparam logic [4:0] ALU_OR     = 5'b00011;
    localparam logic [4:0] ALU_XOR    = 5'b00100;
    localparam logic [4:0] ALU_SLL    = 5'b00101;
    localparam logic [4:0] ALU_SRL    = 5'b00110;
    localparam logic [4:0] ALU_SRA    = 5'b00111;
    localparam logic [4:0] ALU_ADDW   = 5'b01000;
    localparam logic [4:0] ALU_SUBW   = 5'b01001;
    localparam logic [4:0] ALU_SLT    = 5'b01010;
    localparam logic [4:0] ALU_SLTU   = 5'b01011;
    localparam logic [4:0] ALU_SLLW   = 5'b01100;
    localparam logic [4:0] ALU_SRLW   = 5'b01101;
    localparam logic [4:0] ALU_SRAW   = 5'b01110;
    localparam logic [4:0] ALU_SH1ADD = 5'b10000;
    localparam logic [4:0] ALU_SH2ADD = 5'b10001;
    localparam logic [4:0] ALU_SH3ADD = 5'b10010;
    localparam logic [4:0] ALU_ADDUW  = 5'b10011;
    localparam logic [4:0] ALU_SH1UW  = 5'b10100;
    localparam logic [4:0] ALU_SH2UW  = 5'b10101;
    localparam logic [4:0] ALU_SH3UW  = 5'b10110;

    // Counter preload is LAT-1: the load cycle itself is the first EX cycle.
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    typedef struct packed {
        logic       valid;
        logic [1:0] result_src;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       branch;
        logic       jump;
        logic       is_jalr;
        logic [2:0] imm_src;
        logic [4:0] alu_control;
        logic       illegal;
    } ctrl_t;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             legal;
    logic             is_mul;
    logic             is_div;
    ctrl_t            dec;
    ctrl_t            ex_q;
    logic [CNT_W-1:0] cnt;
    logic             unused_fields;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    // Register numbers and immediates are handled in other stages.
    assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

    // Decode instr_i into a control bundle; illegal encodings collapse to valid+illegal only.
    always_comb begin
        dec    = '0;
        legal  = 1'b0;
        is_mul = 1'b0;
        is_div = 1'b0;
        case (opcode)
            OPC_LOAD: begin
                legal           = (funct3 != 3'b111);
                dec.result_src  = 2'b01;
                dec.alu_src     = 1'b1;
                dec.reg_write   = 1'b1;
                dec.imm_src     = IMM_I;
                dec.alu_control = ALU_ADD;
            end
            OPC_STORE: begin
                legal           = !funct3[2];
                dec.mem_write   = 1'b1;
                dec.alu_src     = 1'b1;
                dec.imm_src     = IMM_S;
                dec.alu_control = ALU_ADD;
            end
            OPC_OP: begin
                dec.reg_write = 1'b1;
                case (funct7)
                    7'b0000000: begin
                        legal = 1'b1;
                        case (funct3)
                            3'b000:  dec.alu_control = ALU_ADD;
                            3'b001:  dec.alu_control = ALU_SLL;
                            3'b010:  dec.alu_control = ALU_SLT;
                            3'b011:  dec.alu_control = ALU_SLTU;
                            3'b100:  dec.alu_control = ALU_XOR;
                            3'b101:  dec.alu_control = ALU_SRL;
                            3'b110:  dec.alu_control = ALU_OR;
                            default: dec.alu_control = ALU_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000) begin
                            legal = 1'b1;
                            dec.alu_control = ALU_SUB;
                        end else if (funct3 == 3'b101) begin
                            legal = 1'b1;
                            dec.alu_control = ALU_SRA;
                        end
                    end
                    7'b0010000: begin
                        if (EN_ZBA) begin
                            case (funct3)
                                3'b010:  begin legal = 1'b1; dec.alu_control = ALU_SH1ADD; end
                                3'b100:  begin legal = 1'b1; dec.alu_control = ALU_SH2ADD; end
                                3'b110:  begin legal = 1'b1; dec.alu_control = ALU_SH3ADD; end
                                default: legal = 1'b0;
                            endcase
                        end
                    end
                    7'b0000001: begin
                        if (EN_M) begin
                            legal           = 1'b1;
                            dec.alu_control = {2'b11, funct3};
                            is_mul          = !funct3[2];
                            is_div          = funct3[2];
                        end
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP32: begin
                dec.reg_write = 1'b1;
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  begin legal = 1'b1; dec.alu_control = ALU_ADDW; end
                            3'b001:  begin legal = 1'b1; dec.alu_control = ALU_SLLW; end
                            3'b101:  begin legal = 1'b1; dec.alu_control = ALU_SRLW; end
                            default: legal = 1'b0;
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000) begin
                            legal = 1'b1;
                            dec.alu_control = ALU_SUBW;
                        end else if (funct3 == 3'b101) begin
                            legal = 1'b1;
                            dec.alu_control = ALU_SRAW;
                        end
                    end
                    7'b0000100: begin
                        if (EN_ZBA && funct3 == 3'b000) begin
                            legal = 1'b1;
                            dec.alu_control = ALU_ADDUW;
                        end
                    end
                    7'b0010000: begin
                        if (EN_ZBA) begin
                            case (funct3)
                                3'b010:  begin legal = 1'b1; dec.alu_control = ALU_SH1UW; end
                                3'b100:  begin legal = 1'b1; dec.alu_control = ALU_SH2UW; end
                                3'b110:  begin legal = 1'b1; dec.alu_control = ALU_SH3UW; end
                                default: legal = 1'b0;
                            endcase
                        end
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_OPIMM: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm_src   = IMM_I;
                case (funct3)
                    3'b000: begin legal = 1'b1; dec.alu_control = ALU_ADD;  end
                    3'b010: begin legal = 1'b1; dec.alu_control = ALU_SLT;  end
                    3'b011: begin legal = 1'b1; dec.alu_control = ALU_SLTU; end
                    3'b100: begin legal = 1'b1; dec.alu_control = ALU_XOR;  end
                    3'b110: begin legal = 1'b1; dec.alu_control = ALU_OR;   end
                    3'b111: begin legal = 1'b1; dec.alu_control = ALU_AND;  end
                    3'b001: begin
                        legal = (instr_i[31:26] == 6'b000000);
                        dec.alu_control = ALU_SLL;
                    end
                    default: begin
                        legal = (instr_i[31:26] == 6'b000000) || (instr_i[31:26] == 6'b010000);
                        dec.alu_control = instr_i[30] ? ALU_SRA : ALU_SRL;
                    end
                endcase
            end
            OPC_OPIMM32: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm_src   = IMM_I;
                case (funct3)
                    3'b000: begin legal = 1'b1; dec.alu_control = ALU_ADDW; end
                    3'b001: begin
                        legal = (funct7 == 7'b0000000);
                        dec.alu_control = ALU_SLLW;
                    end
                    3'b101: begin
                        legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                        dec.alu_control = funct7[5] ? ALU_SRAW : ALU_SRLW;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                legal          = 1'b1;
                dec.result_src = 2'b11;
                dec.reg_write  = 1'b1;
                dec.imm_src    = IMM_U;
            end
            OPC_AUIPC: begin
                legal         = 1'b1;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm_src   = IMM_U;
            end
            OPC_BRANCH: begin
                dec.branch  = 1'b1;
                dec.imm_src = IMM_B;
                case (funct3)
                    3'b000, 3'b001: begin legal = 1'b1; dec.alu_control = ALU_SUB;  end
                    3'b100, 3'b101: begin legal = 1'b1; dec.alu_control = ALU_SLT;  end
                    3'b110, 3'b111: begin legal = 1'b1; dec.alu_control = ALU_SLTU; end
                    default:        legal = 1'b0;
                endcase
            end
            OPC_JAL: begin
                legal          = 1'b1;
                dec.result_src = 2'b10;
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.imm_src    = IMM_J;
            end
            OPC_JALR: begin
                legal           = (funct3 == 3'b000);
                dec.result_src  = 2'b10;
                dec.alu_src     = 1'b1;
                dec.reg_write   = 1'b1;
                dec.jump        = 1'b1;
                dec.is_jalr     = 1'b1;
                dec.imm_src     = IMM_I;
                dec.alu_control = ALU_ADD;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
            is_mul      = 1'b0;
            is_div      = 1'b0;
        end
        dec.valid = 1'b1;
    end

    assign md_busy = (cnt != '0);
    assign stall_o = stall_i | md_busy;

    // ID/EX register and MUL/DIV occupancy counter: reset, then flush, then stall, then load.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
            cnt  <= '0;
        end else if (flush_i) begin
            ex_q <= '0;
            cnt  <= '0;
        end else if (stall_o) begin
            if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end else if (valid_i) begin
            ex_q <= dec;
            if (is_mul) begin
                cnt <= MUL_CNT;
            end else if (is_div) begin
                cnt <= DIV_CNT;
            end else begin
                cnt <= '0;
            end
        end else begin
            ex_q <= '0;
            cnt  <= '0;
        end
    end

    assign e_valid      = ex_q.valid;
    assign e_ResultSrc  = ex_q.result_src;
    assign e_MemWrite   = ex_q.mem_write;
    assign e_ALUSrc     = ex_q.alu_src;
    assign e_RegWrite   = ex_q.reg_write;
    assign e_Branch     = ex_q.branch;
    assign e_Jump       = ex_q.jump;
    assign e_is_jalr    = ex_q.is_jalr;
    assign e_ImmSrc     = ex_q.imm_src;
    assign e_ALUControl = ex_q.alu_control;
    assign e_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb_decode_ctrl_stage: directed vectors against two configurations sharing
// the same stimulus (full-featured, and Zba disabled with short latencies).
module tb_decode_ctrl_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_i;
    logic        valid_i;
    logic        stall_i;
    logic        flush_i;

    logic        a_valid, a_mw, a_as, a_rw, a_br, a_jp, a_jr, a_ill, a_busy, a_stall;
    logic [1:0]  a_rs;
    logic [2:0]  a_imm;
    logic [4:0]  a_alu;
    logic        b_valid, b_mw, b_as, b_rw, b_br, b_jp, b_jr, b_ill, b_busy, b_stall;
    logic [1:0]  b_rs;
    logic [2:0]  b_imm;
    logic [4:0]  b_alu;
    logic [17:0] a_bus, b_bus;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decode_ctrl_stage #(.EN_ZBA(1'b1), .EN_M(1'b1), .MUL_LAT(3), .DIV_LAT(33), .CNT_W(6)) dut_a (
        .clk(clk), .rst(rst), .instr_i(instr_i), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
        .e_valid(a_valid), .e_ResultSrc(a_rs), .e_MemWrite(a_mw), .e_ALUSrc(a_as), .e_RegWrite(a_rw),
        .e_Branch(a_br), .e_Jump(a_jp), .e_is_jalr(a_jr), .e_ImmSrc(a_imm), .e_ALUControl(a_alu),
        .e_illegal(a_ill), .md_busy(a_busy), .stall_o(a_stall)
    );

    decode_ctrl_stage #(.EN_ZBA(1'b0), .EN_M(1'b1), .MUL_LAT(1), .DIV_LAT(2), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .instr_i(instr_i), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
        .e_valid(b_valid), .e_ResultSrc(b_rs), .e_MemWrite(b_mw), .e_ALUSrc(b_as), .e_RegWrite(b_rw),
        .e_Branch(b_br), .e_Jump(b_jp), .e_is_jalr(b_jr), .e_ImmSrc(b_imm), .e_ALUControl(b_alu),
        .e_illegal(b_ill), .md_busy(b_busy), .stall_o(b_stall)
    );

    assign a_bus = {a_valid, a_rs, a_mw, a_as, a_rw, a_br, a_jp, a_jr, a_imm, a_alu, a_ill};
    assign b_bus = {b_valid, b_rs, b_mw, b_as, b_rw, b_br, b_jp, b_jr, b_imm, b_alu, b_ill};

    function automatic logic [17:0] mk(input logic v, input logic [1:0] rs, input logic mw,
                                       input logic as, input logic rw, input logic br,
                                       input logic jp, input logic jr, input logic [2:0] imm,
                                       input logic [4:0] alu, input logic ill);
        return {v, rs, mw, as, rw, br, jp, jr, imm, alu, ill};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_ADD  = 32'h003100B3;
    localparam logic [31:0] I_DIV  = 32'h0220C0B3;
    localparam logic [31:0] I_MUL  = 32'h022080B3;
    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_LW   = 32'h0000A083;

    logic [17:0] e_zero, e_ill, e_add, e_div, e_mul, e_addi, e_sw;
    logic [31:0] v_instr [15];
    logic [17:0] v_exp_a [15];
    logic [17:0] v_exp_b [15];

    initial begin
        e_zero = '0;
        e_ill  = mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 3'b000, 5'b00000, 1);
        e_add  = mk(1, 2'b00, 0, 0, 1, 0, 0, 0, 3'b000, 5'b00000, 0);
        e_div  = mk(1, 2'b00, 0, 0, 1, 0, 0, 0, 3'b000, 5'b11100, 0);
        e_mul  = mk(1, 2'b00, 0, 0, 1, 0, 0, 0, 3'b000, 5'b11000, 0);
        e_addi = mk(1, 2'b00, 0, 1, 1, 0, 0, 0, 3'b000, 5'b00000, 0);
        e_sw   = mk(1, 2'b00, 1, 1, 0, 0, 0, 0, 3'b001, 5'b00000, 0);

        v_instr[0]  = I_LW;         v_exp_a[0]  = mk(1, 2'b01, 0, 1, 1, 0, 0, 0, 3'b000, 5'b00000, 0);
        v_instr[1]  = I_SW;         v_exp_a[1]  = e_sw;
        v_instr[2]  = 32'h0020C063; v_exp_a[2]  = mk(1, 2'b00, 0, 0, 0, 1, 0, 0, 3'b010, 5'b01010, 0);
        v_instr[3]  = 32'h000000EF; v_exp_a[3]  = mk(1, 2'b10, 0, 0, 1, 0, 1, 0, 3'b100, 5'b00000, 0);
        v_instr[4]  = 32'h000100E7; v_exp_a[4]  = mk(1, 2'b10, 0, 1, 1, 0, 1, 1, 3'b000, 5'b00000, 0);
        v_instr[5]  = 32'h123450B7; v_exp_a[5]  = mk(1, 2'b11, 0, 0, 1, 0, 0, 0, 3'b011, 5'b00000, 0);
        v_instr[6]  = I_ADDI;       v_exp_a[6]  = e_addi;
        v_instr[7]  = 32'h400050BB; v_exp_a[7]  = mk(1, 2'b00, 0, 0, 1, 0, 0, 0, 3'b000, 5'b01110, 0);
        v_instr[8]  = 32'h080000BB; v_exp_a[8]  = mk(1, 2'b00, 0, 0, 1, 0, 0, 0, 3'b000, 5'b10011, 0);
        v_instr[9]  = 32'h2020A0B3; v_exp_a[9]  = mk(1, 2'b00, 0, 0, 1, 0, 0, 0, 3'b000, 5'b10000, 0);
        v_instr[10] = 32'h022080BB; v_exp_a[10] = e_ill;
        v_instr[11] = 32'h0000007F; v_exp_a[11] = e_ill;
        v_instr[12] = 32'h400010B3; v_exp_a[12] = e_ill;
        v_instr[13] = 32'h0020F063; v_exp_a[13] = mk(1, 2'b00, 0, 0, 0, 1, 0, 0, 3'b010, 5'b01011, 0);
        v_instr[14] = 32'h4030D093; v_exp_a[14] = mk(1, 2'b00, 0, 1, 1, 0, 0, 0, 3'b000, 5'b00111, 0);
        for (int i = 0; i < 15; i++) v_exp_b[i] = v_exp_a[i];
        v_exp_b[8] = e_ill;
        v_exp_b[9] = e_ill;

        rst = 1'b1; instr_i = '0; valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        tick();
        tick();
        chk("rst_bus_a", 32'(a_bus), 32'(e_zero));
        chk("rst_busy_a", 32'(a_busy), 32'd0);
        chk("rst_stall_a", 32'(a_stall), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_bus_a", 32'(a_bus), 32'(e_zero));
        chk("idle_bus_b", 32'(b_bus), 32'(e_zero));

        instr_i = I_ADD; valid_i = 1'b1;
        tick();
        chk("add_a", 32'(a_bus), 32'(e_add));
        chk("add_b", 32'(b_bus), 32'(e_add));

        for (int i = 0; i < 15; i++) begin
            instr_i = v_instr[i];
            tick();
            chk($sformatf("vec%0d_a", i), 32'(a_bus), 32'(v_exp_a[i]));
            chk($sformatf("vec%0d_b", i), 32'(b_bus), 32'(v_exp_b[i]));
            chk($sformatf("vec%0d_stall", i), 32'(a_stall), 32'd0);
        end

        instr_i = I_ADD; valid_i = 1'b0;
        tick();
        chk("bubble_a", 32'(a_bus), 32'(e_zero));

        // DIV occupies EX for 33 cycles; the following ADD loads on cycle 34.
        instr_i = I_DIV; valid_i = 1'b1;
        tick();
        chk("div_busy_b", 32'(b_busy), 32'd1);
        instr_i = I_ADD;
        for (int i = 1; i <= 32; i++) begin
            chk($sformatf("div_c%0d_bus", i), 32'(a_bus), 32'(e_div));
            chk($sformatf("div_c%0d_busy", i), 32'(a_busy), 32'd1);
            chk($sformatf("div_c%0d_stall", i), 32'(a_stall), 32'd1);
            tick();
        end
        chk("div_c33_bus", 32'(a_bus), 32'(e_div));
        chk("div_c33_busy", 32'(a_busy), 32'd0);
        chk("div_c33_stall", 32'(a_stall), 32'd0);
        tick();
        chk("div_next_add", 32'(a_bus), 32'(e_add));

        // MUL aborted by a flush that coincides with a stall request.
        instr_i = I_MUL;
        tick();
        chk("mul_a", 32'(a_bus), 32'(e_mul));
        chk("mul_busy_a", 32'(a_busy), 32'd1);
        chk("mul_b", 32'(b_bus), 32'(e_mul));
        chk("mul_lat1_busy_b", 32'(b_busy), 32'd0);
        instr_i = I_ADD; flush_i = 1'b1; stall_i = 1'b1;
        tick();
        chk("flush_bus", 32'(a_bus), 32'(e_zero));
        chk("flush_busy", 32'(a_busy), 32'd0);
        chk("flush_stall_hi", 32'(a_stall), 32'd1);
        stall_i = 1'b0;
        #1;
        chk("flush_stall_lo", 32'(a_stall), 32'd0);
        flush_i = 1'b0;
        tick();
        chk("post_flush_add", 32'(a_bus), 32'(e_add));

        // Back-to-back MULs: second loads when md_busy falls.
        instr_i = I_MUL;
        tick();
        chk("b2b_c1_busy", 32'(a_busy), 32'd1);
        tick();
        chk("b2b_c2_busy", 32'(a_busy), 32'd1);
        tick();
        chk("b2b_c3_busy", 32'(a_busy), 32'd0);
        chk("b2b_c3_stall", 32'(a_stall), 32'd0);
        tick();
        chk("b2b_c4_busy", 32'(a_busy), 32'd1);
        chk("b2b_c4_bus", 32'(a_bus), 32'(e_mul));
        instr_i = I_ADD;
        tick();
        chk("b2b_c5_busy", 32'(a_busy), 32'd1);
        tick();
        chk("b2b_c6_busy", 32'(a_busy), 32'd0);
        chk("b2b_c6_bus", 32'(a_bus), 32'(e_mul));
        tick();
        chk("b2b_c7_add", 32'(a_bus), 32'(e_add));

        // External stall holds ID/EX while instr_i keeps changing.
        instr_i = I_ADDI;
        tick();
        chk("pre_stall_addi", 32'(a_bus), 32'(e_addi));
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr_i = (i == 0) ? I_LW : (i == 1) ? I_SW : 32'h0000007F;
            tick();
            chk($sformatf("stall%0d_bus", i), 32'(a_bus), 32'(e_addi));
            chk($sformatf("stall%0d_out", i), 32'(a_stall), 32'd1);
        end
        stall_i = 1'b0;
        instr_i = I_SW;
        tick();
        chk("unstall_sw", 32'(a_bus), 32'(e_sw));

        // Reset in the middle of a DIV leaves no residual stall.
        instr_i = I_DIV;
        tick();
        chk("pre_rst_busy", 32'(a_busy), 32'd1);
        rst = 1'b1;
        valid_i = 1'b0;
        tick();
        chk("mid_rst_bus", 32'(a_bus), 32'(e_zero));
        chk("mid_rst_busy", 32'(a_busy), 32'd0);
        chk("mid_rst_stall", 32'(a_stall), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_bus", 32'(a_bus), 32'(e_zero));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
